// File: rtl/encoder_pkg.sv
// Shared definitions for the 8-to-3 priority encoder.
//   IN_W  : width of the request vector
//   OUT_W : width of the encoded index
//   req_t : request vector type
//   idx_t : encoded index type
package encoder_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 3;

  typedef logic [IN_W-1:0]  req_t;
  typedef logic [OUT_W-1:0] idx_t;

endpackage : encoder_pkg

// File: rtl/encoder_8to3_core.sv
// Combinational core of the 8-to-3 priority encoder.
// Parameters:
//   LSB_PRIORITY : 0 -> highest set bit wins, 1 -> lowest set bit wins
// Ports:
//   d          in  request vector
//   y_next     out index of the winning bit (0 when d is all zero)
//   valid_next out any bit of d set
//   multi_next out two or more bits of d set
module encoder_8to3_core
  import encoder_pkg::*;
#(
  parameter int unsigned LSB_PRIORITY = 0
) (
  input  req_t d,
  output idx_t y_next,
  output logic valid_next,
  output logic multi_next
);

  always_comb begin
    y_next = '0;
    // Scan from the lowest-priority end so the last hit is the winner.
    if (LSB_PRIORITY != 0) begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (d[i]) y_next = idx_t'(i);
      end
    end else begin
      for (int i = 0; i < IN_W; i++) begin
        if (d[i]) y_next = idx_t'(i);
      end
    end
  end

  assign valid_next = |d;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_next = |(d & (d - req_t'(1)));

endmodule : encoder_8to3_core

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder.
// Parameters:
//   LSB_PRIORITY : 0 -> highest set bit wins, 1 -> lowest set bit wins
// Ports:
//   clk   in  clock, all state updates on rising edge
//   rst   in  synchronous active-high reset, overrides en
//   en    in  capture enable; outputs hold while low
//   d     in  request vector
//   y     out registered index of winning bit
//   valid out registered "any bit set"
//   multi out registered "two or more bits set"
module encoder_8to3
  import encoder_pkg::*;
#(
  parameter int unsigned LSB_PRIORITY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi
);

  idx_t w_y_next;
  logic w_valid_next;
  logic w_multi_next;

  idx_t r_y;
  logic r_valid;
  logic r_multi;

  encoder_8to3_core #(
    .LSB_PRIORITY (LSB_PRIORITY)
  ) u_core (
    .d          (d),
    .y_next     (w_y_next),
    .valid_next (w_valid_next),
    .multi_next (w_multi_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else if (en) begin
      r_y     <= w_y_next;
      r_valid <= w_valid_next;
      r_multi <= w_multi_next;
    end
  end

  assign y     = r_y;
  assign valid = r_valid;
  assign multi = r_multi;

endmodule : encoder_8to3

// File: tb/tb_encoder_8to3.sv
// Testbench for encoder_8to3: one instance per priority order, driven by the
// same stimulus and checked against an arithmetic reference model.
module tb_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] d;
  logic [2:0] y_m, y_l;
  logic       valid_m, valid_l, multi_m, multi_l;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state
  logic [2:0] exp_y_m, exp_y_l;
  logic       exp_valid, exp_multi;

  always #5 clk = ~clk;

  encoder_8to3 #(.LSB_PRIORITY(0)) u_msb (
    .clk(clk), .rst(rst), .en(en), .d(d),
    .y(y_m), .valid(valid_m), .multi(multi_m)
  );

  encoder_8to3 #(.LSB_PRIORITY(1)) u_lsb (
    .clk(clk), .rst(rst), .en(en), .d(d),
    .y(y_l), .valid(valid_l), .multi(multi_l)
  );

  // floor(log2(v)) by repeated halving; 0 for v == 0
  function automatic logic [2:0] model_msb(input int unsigned v);
    int n = 0;
    while (v > 1) begin
      v = v / 2;
      n++;
    end
    return 3'(n);
  endfunction

  // count of trailing zeros by repeated division; 0 for v == 0
  function automatic logic [2:0] model_lsb(input int unsigned v);
    int n = 0;
    if (v == 0) return 3'd0;
    while (v % 2 == 0) begin
      v = v / 2;
      n++;
    end
    return 3'(n);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, compare both instances.
  task automatic cycle(input logic r, input logic e, input logic [7:0] dd);
    rst = r;
    en  = e;
    d   = dd;
    @(posedge clk);
    #1;
    if (r) begin
      exp_y_m = 3'd0; exp_y_l = 3'd0; exp_valid = 1'b0; exp_multi = 1'b0;
    end else if (e) begin
      exp_y_m   = model_msb(int'(dd));
      exp_y_l   = model_lsb(int'(dd));
      exp_valid = (dd != 8'h00);
      exp_multi = ($countones(dd) >= 2);
    end
    $display("rst=%0b en=%0b d=%02h | msb y=%0d v=%0b m=%0b | lsb y=%0d v=%0b m=%0b",
             r, e, dd, y_m, valid_m, multi_m, y_l, valid_l, multi_l);
    check("msb_y",     int'(y_m),     int'(exp_y_m));
    check("msb_valid", int'(valid_m), int'(exp_valid));
    check("msb_multi", int'(multi_m), int'(exp_multi));
    check("lsb_y",     int'(y_l),     int'(exp_y_l));
    check("lsb_valid", int'(valid_l), int'(exp_valid));
    check("lsb_multi", int'(multi_l), int'(exp_multi));
  endtask

  initial begin
    logic [7:0] sweep [8];
    sweep = '{8'h00, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    exp_y_m = '0; exp_y_l = '0; exp_valid = 1'b0; exp_multi = 1'b0;

    // 1. Reset with everything else asserted
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hFF);
    check("reset_y", int'(y_m), 0);
    check("reset_valid", int'(valid_m), 0);

    // 2. One-hot sweep, including 0x00 and a bit-0 one-hot
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, sweep[i]);
      check("sweep_y", int'(y_m), i);
    end
    cycle(1'b0, 1'b1, 8'h01);
    check("onehot0_y", int'(y_m), 0);
    check("onehot0_valid", int'(valid_m), 1);

    // 3./4. Multi-hot priority in both orders
    cycle(1'b0, 1'b1, 8'h0A);
    check("p3_msb_y", int'(y_m), 3);
    check("p3_msb_multi", int'(multi_m), 1);
    check("p4_lsb_y", int'(y_l), 1);
    cycle(1'b0, 1'b1, 8'h81);
    check("p3_msb_y81", int'(y_m), 7);
    cycle(1'b0, 1'b1, 8'h80);
    check("p4_lsb_y80", int'(y_l), 7);
    check("p4_lsb_multi80", int'(multi_l), 0);

    // 5. Hold while en is low
    cycle(1'b0, 1'b1, 8'h10);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'h01);
      check("hold_y", int'(y_m), 4);
      check("hold_valid", int'(valid_m), 1);
    end

    // 6. Reset mid-stream wins over enable
    cycle(1'b0, 1'b1, 8'h40);
    check("pre_rst_y", int'(y_m), 6);
    cycle(1'b1, 1'b1, 8'h80);
    check("rst_en_y", int'(y_m), 0);
    check("rst_en_valid", int'(valid_m), 0);
    cycle(1'b0, 1'b1, 8'h80);
    check("post_rst_y", int'(y_m), 7);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
            8'($urandom_range(0, 255)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_encoder_8to3
